tx_scheduler: RTL

TX_SCHEDULER -- requirements
Module: tx_scheduler

---
 rtl/tx_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tx_scheduler.sv
// tx_scheduler: round-robin arbiter feeding one UART from an echo requester and a
// locked multi-byte result requester. Optional CR/LF trailer: define TX_CRLF_EN.
module tx_scheduler #(
  parameter int         LOCK_TIMEOUT = 255,
  parameter logic [7:0] CR_CHAR      = 8'h0D,
  parameter logic [7:0] LF_CHAR      = 8'h0A
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       echo_valid,
  input  logic [7:0] echo_data,
  output logic       echo_ready,
  input  logic       res_valid,
  input  logic [7:0] res_data,
  input  logic       res_last,
  output logic       res_ready,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic [1:0] grant,
  output logic       err_timeout,
  output logic [2:0] dbg_state
);

  localparam int CW = ($clog2(LOCK_TIMEOUT + 1) > 8) ? $clog2(LOCK_TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    GUARD = 3'd2,
    WAIT  = 3'd3
`ifdef TX_CRLF_EN
    , TERM_CR = 3'd4
    , TERM_LF = 3'd5
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      data_q;
  logic [1:0]      grant_q;
  logic            lock_q;
  logic            ptr_q;
  logic            last_q;
  logic [CW-1:0]   cnt_q;
  logic            term_active;

  logic echo_ok, pick_res, pick_echo;
  logic accept_echo, accept_res, wait_exit, msg_done, timeout_hit;

`ifdef TX_CRLF_EN
  logic [1:0] term_q;
  assign term_active = (term_q != 2'd0);
`else
  assign term_active = 1'b0;
`endif

  // Handshake: a requester byte transfers in the cycle where its valid and ready
  // are both high; ready is combinational and only offered in IDLE with tx_ready.
  always_comb begin
    echo_ok     = echo_valid && !lock_q;
    pick_res    = res_valid && (ptr_q || !echo_ok);
    pick_echo   = echo_ok && !pick_res;
    accept_res  = n_rst && (state_q == IDLE) && tx_ready && pick_res;
    accept_echo = n_rst && (state_q == IDLE) && tx_ready && pick_echo;
    wait_exit   = (state_q == WAIT) && tx_ready;
    // last_q is forced high for echo bytes, so this marks any finished message.
    msg_done    = wait_exit && !term_active && last_q;
    timeout_hit = (state_q == IDLE) && lock_q && !accept_res && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      grant_q <= 2'b00;
      lock_q  <= 1'b0;
      ptr_q   <= 1'b1;
      last_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef TX_CRLF_EN
      term_q  <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      if (accept_echo) begin
        data_q  <= echo_data;
        grant_q <= 2'b01;
        last_q  <= 1'b1;
      end else if (accept_res) begin
        data_q  <= res_data;
        grant_q <= 2'b10;
        last_q  <= res_last;
        lock_q  <= 1'b1;
`ifdef TX_CRLF_EN
      end else if (state_q == TERM_CR) begin
        data_q <= CR_CHAR;
      end else if (state_q == TERM_LF) begin
        data_q <= LF_CHAR;
`endif
      end
      if (msg_done || timeout_hit) begin
        ptr_q  <= ~ptr_q;
        lock_q <= 1'b0;
      end
      if (timeout_hit || (wait_exit && state_d == IDLE && last_q))
        grant_q <= 2'b00;
      if (accept_res || msg_done || timeout_hit)
        cnt_q <= '0;
      else if (state_q == IDLE && lock_q)
        cnt_q <= cnt_q + 1'b1;
`ifdef TX_CRLF_EN
      if (state_q == TERM_CR)
        term_q <= 2'd1;
      else if (state_q == TERM_LF)
        term_q <= 2'd2;
      else if (wait_exit && term_q == 2'd2)
        term_q <= 2'd0;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept_echo || accept_res) state_d = ISSUE;
      ISSUE: state_d = GUARD;
      GUARD: state_d = WAIT;
      WAIT: begin
        if (tx_ready) begin
`ifdef TX_CRLF_EN
          if (term_q == 2'd1)
            state_d = TERM_LF;
          else if (term_q == 2'd0 && grant_q[1] && last_q)
            state_d = TERM_CR;
          else
            state_d = IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef TX_CRLF_EN
      TERM_CR, TERM_LF: state_d = ISSUE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_valid    = (state_q == ISSUE);
    tx_data     = data_q;
    grant       = grant_q;
    echo_ready  = accept_echo;
    res_ready   = accept_res;
    err_timeout = timeout_hit;
    dbg_state   = state_q;
  end

endmodule
